// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous double buffering.
// Outputs are registered from next-state values so they track div_cnt/digit_idx with no lag.
module seven_seg_scan #(
  parameter int unsigned DIV = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lzb,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        pending
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [19:0]   disp_q, disp_d;
  logic [19:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          div_wrap, frame_end, blank, dp_bit;
  logic [3:0]    nib;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    case (v)
      4'h0: hex2seg = 7'b1000000;
      4'h1: hex2seg = 7'b1111001;
      4'h2: hex2seg = 7'b0100100;
      4'h3: hex2seg = 7'b0110000;
      4'h4: hex2seg = 7'b0011001;
      4'h5: hex2seg = 7'b0010010;
      4'h6: hex2seg = 7'b0000010;
      4'h7: hex2seg = 7'b1111000;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0010000;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b0000011;
      4'hC: hex2seg = 7'b1000110;
      4'hD: hex2seg = 7'b0100001;
      4'hE: hex2seg = 7'b0000110;
      default: hex2seg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    div_wrap    = (div_cnt_q == CW'(DIV - 1));
    frame_end   = div_wrap && (digit_idx_q == 2'd3);
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = div_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

    // Shadow is read before this edge's load lands, so a coincident load waits a frame.
    disp_d    = (frame_end && pending_q) ? shadow_q : disp_q;
    shadow_d  = load ? {dp_in, data_in} : shadow_q;
    pending_d = load ? 1'b1 : (frame_end ? 1'b0 : pending_q);

    nib    = disp_d[3:0];
    dp_bit = disp_d[16];
    blank  = 1'b0;
    case (digit_idx_d)
      2'd0: begin nib = disp_d[3:0];   dp_bit = disp_d[16]; end
      2'd1: begin nib = disp_d[7:4];   dp_bit = disp_d[17]; blank = lzb && (disp_d[15:4] == 12'h000); end
      2'd2: begin nib = disp_d[11:8];  dp_bit = disp_d[18]; blank = lzb && (disp_d[15:8] == 8'h00); end
      default: begin nib = disp_d[15:12]; dp_bit = disp_d[19]; blank = lzb && (disp_d[15:12] == 4'h0); end
    endcase

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    // First cycle of each dwell stays dark so the anode switch never shows stale segments.
    if ((div_cnt_d != '0) && !blank) begin
      an_d  = ~(4'b0001 << digit_idx_d);
      seg_d = hex2seg(nib);
      dp_d  = ~dp_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q   <= '0;
      digit_idx_q <= 2'd0;
      disp_q      <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      disp_q      <= disp_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed plus randomized bench for seven_seg_scan (DIV=4) against a time-indexed reference model.
module tb_seven_seg_scan;

  localparam int DIV = 4;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;

  seven_seg_scan #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .lzb(lzb), .seg(seg), .dp(dp), .an(an), .pending(pending)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: t counts clock edges since reset release.
  int          t = 0;
  logic [19:0] m_disp = '0;
  logic [19:0] m_shadow = '0;
  logic        m_pend = 1'b0;
  logic        m_lzb = 1'b0;

  function automatic int m_cnt();
    return t % DIV;
  endfunction

  function automatic int m_idx();
    return (t / DIV) % 4;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic check_model();
    int idx, val;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    idx = m_idx();
    val = int'(m_disp[15:0]);
    ea = 4'hF; es = 7'h7F; ed = 1'b1;
    if (m_cnt() != 0 && !(m_lzb && idx > 0 && (val >> (4 * idx)) == 0)) begin
      ea[idx] = 1'b0;
      es = SEG[(val >> (4 * idx)) & 15];
      ed = ~m_disp[16 + idx];
    end
    chk("an",      {4'b0, an},      {4'b0, ea});
    chk("seg",     {1'b0, seg},     {1'b0, es});
    chk("dp",      {7'b0, dp},      {7'b0, ed});
    chk("pending", {7'b0, pending}, {7'b0, m_pend});
  endtask

  // Called at a negedge; drives inputs, clocks once, updates model, checks at next negedge.
  task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] p);
    logic boundary;
    load = ld;
    if (ld) begin
      data_in = d;
      dp_in   = p;
    end
    @(posedge clk);
    boundary = (m_cnt() == DIV - 1) && (m_idx() == 3);
    if (boundary && m_pend) m_disp = m_shadow;
    if (ld) begin
      m_shadow = {p, d};
      m_pend   = 1'b1;
    end else if (boundary) begin
      m_pend = 1'b0;
    end
    m_lzb = lzb;
    t++;
    @(negedge clk);
    load = 1'b0;
    check_model();
  endtask

  task automatic run_until(input int idx, input int cnt);
    int n = 0;
    do begin
      cycle(1'b0, 16'h0, 4'h0);
      n++;
    end while (!(m_idx() == idx && m_cnt() == cnt) && n < 64);
    vectors++;
    assert (n < 64) else begin
      errors++;
      $error("FAIL run_until timeout: observed %0d cycles expected fewer than 64", n);
    end
  endtask

  initial begin
    // Reset with a load strobe that must be ignored.
    rst = 1'b1; load = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk("rst_an",      {4'b0, an},      8'h0F);
    chk("rst_seg",     {1'b0, seg},     8'h7F);
    chk("rst_dp",      {7'b0, dp},      8'h01);
    chk("rst_pending", {7'b0, pending}, 8'h00);
    rst = 1'b0;
    check_model();

    // Scan order over more than a frame, display all zeros.
    repeat (20) cycle(1'b0, 16'h0, 4'h0);

    // Load latency.
    run_until(1, 1);
    cycle(1'b1, 16'h1234, 4'h0);
    chk("lat_pending", {7'b0, pending}, 8'h01);
    run_until(0, 1);
    chk("lat_d0_seg",  {1'b0, seg},     {1'b0, 7'b0011001});
    chk("lat_pend0",   {7'b0, pending}, 8'h00);
    run_until(3, 1);
    chk("lat_d3_seg",  {1'b0, seg},     {1'b0, 7'b1111001});

    // Last load wins within a frame.
    run_until(0, 2);
    cycle(1'b1, 16'h1111, 4'h0);
    repeat (3) cycle(1'b0, 16'h0, 4'h0);
    cycle(1'b1, 16'h2222, 4'h0);
    for (int k = 0; k < 4; k++) begin
      run_until(k, 2);
      chk("lw_seg", {1'b0, seg}, {1'b0, 7'b0100100});
    end

    // Load coinciding with the frame boundary.
    run_until(3, 3);
    cycle(1'b1, 16'hABCD, 4'h0);
    chk("bnd_pending", {7'b0, pending}, 8'h01);
    run_until(0, 1);
    chk("bnd_old_seg", {1'b0, seg},     {1'b0, 7'b0100100});
    chk("bnd_pend1",   {7'b0, pending}, 8'h01);
    run_until(0, 1);
    chk("bnd_new_seg", {1'b0, seg},     {1'b0, 7'b0100001});

    // Leading-zero blanking.
    cycle(1'b1, 16'h0050, 4'b0100);
    lzb = 1'b1;
    repeat (2 * 4 * DIV) cycle(1'b0, 16'h0, 4'h0);
    run_until(3, 1);
    chk("lzb_d3_an",  {4'b0, an},  8'h0F);
    run_until(2, 2);
    chk("lzb_d2_an",  {4'b0, an},  8'h0F);
    chk("lzb_d2_dp",  {7'b0, dp},  8'h01);
    run_until(1, 1);
    chk("lzb_d1_seg", {1'b0, seg}, {1'b0, 7'b0010010});
    run_until(0, 1);
    chk("lzb_d0_seg", {1'b0, seg}, {1'b0, 7'b1000000});
    lzb = 1'b0;
    run_until(2, 1);
    chk("nolzb_d2_seg", {1'b0, seg}, {1'b0, 7'b1000000});
    chk("nolzb_d2_dp",  {7'b0, dp},  8'h00);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      if (i % 97 == 0) lzb = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      cycle(($urandom_range(0, 5) == 0), d, 4'($urandom));
    end

    // Asynchronous reset in the middle of digit 2's dwell.
    lzb = 1'b0;
    cycle(1'b1, 16'h9876, 4'hF);
    run_until(2, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_an",      {4'b0, an},      8'h0F);
    chk("arst_seg",     {1'b0, seg},     8'h7F);
    chk("arst_pending", {7'b0, pending}, 8'h00);
    t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_lzb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_model();
    run_until(2, 1);
    chk("arst_clear_d2", {1'b0, seg}, {1'b0, 7'b1000000});
    chk("arst_clear_dp", {7'b0, dp},  8'h01);
    run_until(0, 2);
    chk("arst_clear_d0", {1'b0, seg}, {1'b0, 7'b1000000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter DIV, default 25000, meaning clock cycles per digit dwell; legal range 2 to 2^20.
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port data_in  input  16  four hex nibbles; nibble k (bits 4k+3:4k) drives digit k, with digit 0 rightmost.
REQ-005 SHALL have port dp_in  input  4  decimal point request per digit, active-high; sampled together with data_in on load.
REQ-006 SHALL have port load  input  1  single-cycle strobe that captures data_in and dp_in into the shadow register.
REQ-007 SHALL have port lzb  input  1  leading-zero blank enable, sampled live each cycle.
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-010 SHALL have port an  output  4  digit anodes, active-low one-hot or all-off, registered.
REQ-011 SHALL have port pending  output  1  high while the shadow register holds data not yet displayed.

Function
REQ-012 SHALL run div_cnt over 0..DIV-1; when div_cnt is DIV-1, div_cnt SHALL wrap to 0 and digit_idx SHALL advance 0->1->2->3->0.
REQ-013 SHALL define a frame boundary as the cycle in which digit_idx wraps 3->0.
REQ-014 SHALL, on load, write shadow <= {dp_in, data_in} and set pending=1; a later load before the boundary SHALL overwrite the shadow (last wins).
REQ-015 SHALL, at a frame boundary with pending=1, copy shadow to the display register and clear pending, using the shadow value from before that edge.
REQ-016 SHALL, when load coincides with a frame boundary, store the new value in shadow and leave pending=1; that value is applied at the next boundary.
REQ-017 SHALL drive an=1111, seg=1111111 and dp=1 in every cycle where div_cnt==0 (ghost-suppression guard).
REQ-018 SHALL, for all other cycles, drive an[digit_idx]=0 and all other anode bits to 1, with seg and dp decoded from the display register nibble and dp bit of digit_idx.
REQ-019 SHALL make an, seg and dp reflect the div_cnt and digit_idx of the same cycle, with no extra pipeline lag and no glitch between flops.
REQ-020 SHALL use this seg encoding (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 SHALL, with lzb=1, blank digit 3 if its nibble is 0, blank digit 2 if digits 3 and 2 are 0, and blank digit 1 if digits 3..1 are 0; digit 0 is never blanked.
REQ-022 SHALL drive a blanked digit as an=1111, seg=1111111, dp=1 for its whole dwell, overriding dp_in.

Reset
REQ-023 SHALL, while rst=1 and immediately on its assertion, set div_cnt=0, digit_idx=0, display=0, shadow=0, pending=0, an=1111, seg=1111111, dp=1.
REQ-024 SHALL, on the first rising clk edge after rst deasserts, start counting from div_cnt=0 and digit_idx=0, so that digit 0 is lit from the second cycle.
REQ-025 SHALL discard a load asserted while rst=1.

Verification (DIV=4)
REQ-026 SHALL check scan order: after reset release, an per cycle = 1111, 1110, 1110, 1110, 1111, 1101, 1101, 1101, 1111, 1011, ... then 0111, then back to 1110.
REQ-027 SHALL check load latency: load 0x1234 in digit 1 dwell -> pending=1 until the 3->0 boundary; next digit 0 dwell seg=0011001 ("4"), digit 3 dwell seg=1111001 ("1"), pending=0.
REQ-028 SHALL check last-wins: load 0x1111 then 0x2222 within one frame -> only 0x2222 is ever displayed, and every digit shows seg=0100100.
REQ-029 SHALL check boundary coincidence: load 0xABCD on the boundary cycle -> the old value is shown for one more frame, pending=1, then 0xABCD (digit 0 seg=0100001) is shown.
REQ-030 SHALL check lzb: data 0x0050, dp_in=0100, lzb=1 -> digits 3 and 2 are all-off including dp, digit 1 seg=0010010, digit 0 seg=1000000; with lzb=0, digit 2 shows "0" with dp=0.
REQ-031 SHALL check async reset mid-dwell of digit 2 -> an=1111 before the next clk edge, pending=0, and the display clears to 0x0000.
